uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame (legal range 5..9).
REQ-002 Parameter BAUD_PERIOD, default 703, clocks per baud phase.
REQ-003 Parameter ONE_BAUD_PHASE, default 4, phases per bit (even, >=2); HALF = ONE_BAUD_PHASE/2.
REQ-004 Parameter FIFO_AW, default 4, FIFO address width; depth = 2**FIFO_AW.
REQ-005 clk  input  1  system clock; all state on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 rx_din  input  1  asynchronous serial line; idles at 1.
REQ-008 parity_mode  input  3  0 none, 1 odd, 2 even, 3 stick-1, 4 stick-0; 5..7 treated as none.
REQ-009 two_stop  input  1  1 = two stop bits expected, 0 = one.
REQ-010 rd_en  input  1  pop FIFO head.
REQ-011 clr_ovr  input  1  clear overrun flag.
REQ-012 rx_dout  output  DATA_BITS  FIFO head data (show-ahead).
REQ-013 rx_perr  output  1  parity error of head entry.
REQ-014 rx_ferr  output  1  framing error of head entry.
REQ-015 rx_valid  output  1  FIFO not empty.
REQ-016 fifo_count  output  FIFO_AW+1  number of stored entries.
REQ-017 overrun  output  1  sticky: frame dropped because FIFO was full.

Function
REQ-018 rx_din SHALL pass through a 2-FF synchronizer (reset value 2'b11); all decisions use its output (sync).
REQ-019 FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
REQ-020 IDLE: sync==0 -> START; tick and phase counters cleared; parity_mode and two_stop latched (mid-frame changes ignored).
REQ-021 Tick counter counts 0..BAUD_PERIOD-1; on wrap, phase counter advances 0..ONE_BAUD_PHASE-1; phase wrap ends the current bit.
REQ-022 Each bit is sampled once, at tick wrap when phase==HALF-1.
REQ-023 START: sample==1 -> false start, return to IDLE, nothing pushed; else continue to DATA at bit end.
REQ-024 DATA: DATA_BITS samples shifted in LSB first; then PARITY if latched mode is 1..4, else STOP1.
REQ-025 Parity check: odd -> data XOR parity_bit SHALL be 1; even -> 0; stick-1/stick-0 -> bit SHALL equal 1/0; mismatch sets perr.
REQ-026 STOP1/STOP2: ferr set if any stop sample is 0; STOP2 entered only if two_stop latched.
REQ-027 At the mid-bit sample of the last stop bit the FSM SHALL return to IDLE and issue a one-cycle push of {ferr, perr, data} (early return allows resync to the next start bit).
REQ-028 Push with FIFO not full: entry written, count +1; rx_valid high on the following cycle.
REQ-029 Push with FIFO full and no pop: entry discarded, overrun set to 1 on the next cycle.
REQ-030 Simultaneous push and pop when full: both take effect, count unchanged, overrun unchanged.
REQ-031 rd_en with FIFO empty: ignored; count stays 0.
REQ-032 Pointers SHALL wrap modulo depth; entries read out in arrival order.
REQ-033 When empty, rx_dout, rx_perr and rx_ferr SHALL read 0.
REQ-034 overrun cleared only by reset or clr_ovr; set and clear in the same cycle -> set wins.

Reset
REQ-035 reset SHALL force IDLE, counters 0, FIFO pointers 0, fifo_count 0, rx_valid 0, overrun 0, and synchronizer 2'b11, including mid-frame; a partial frame SHALL be discarded.
REQ-036 FIFO memory contents need not be cleared.

Verification (BAUD_PERIOD=4, ONE_BAUD_PHASE=4 -> 16 clk/bit, FIFO_AW=4)
REQ-037 8N1 frame 0x55 -> one push; rx_valid=1, rx_dout=0x55, perr=0, ferr=0, count=1.
REQ-038 Even parity, frame 0xA3 with parity bit 1 -> rx_dout=0xA3, rx_perr=1; same frame with parity bit 0 -> rx_perr=0.
REQ-039 8N1 frame 0x3C with stop bit 0 -> rx_dout=0x3C, rx_ferr=1; two_stop=1 with second stop bit 0 -> rx_ferr=1.
REQ-040 rx_din low for 4 clocks (less than half a bit) -> no push, FSM back in IDLE, count=0.
REQ-041 17 frames 0x00..0x10 with no pops -> count=16, overrun=1, head=0x00; 16 pops yield 0x00..0x0F in order, then rx_valid=0.
REQ-042 reset asserted during the DATA state of a frame -> all outputs at reset values; next 0x81 frame received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver with oversampled bit timing, configurable parity and stop bits,
// feeding a show-ahead FIFO of {ferr, perr, data} entries with a sticky overrun flag.
module uart_rx_fifo #(
    parameter int unsigned DATA_BITS      = 8,
    parameter int unsigned BAUD_PERIOD    = 703,
    parameter int unsigned ONE_BAUD_PHASE = 4,
    parameter int unsigned FIFO_AW        = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_din,
    input  logic [2:0]           parity_mode,
    input  logic                 two_stop,
    input  logic                 rd_en,
    input  logic                 clr_ovr,
    output logic [DATA_BITS-1:0] rx_dout,
    output logic                 rx_perr,
    output logic                 rx_ferr,
    output logic                 rx_valid,
    output logic [FIFO_AW:0]     fifo_count,
    output logic                 overrun
);

    localparam int unsigned HALF    = ONE_BAUD_PHASE / 2;
    localparam int unsigned TICK_W  = (BAUD_PERIOD > 1) ? $clog2(BAUD_PERIOD) : 1;
    localparam int unsigned PHASE_W = (ONE_BAUD_PHASE > 1) ? $clog2(ONE_BAUD_PHASE) : 1;
    localparam int unsigned BIT_W   = $clog2(DATA_BITS + 1);
    localparam int unsigned DEPTH   = 2 ** FIFO_AW;
    localparam int unsigned ENTRY_W = DATA_BITS + 2;
    localparam int unsigned CNT_W   = FIFO_AW + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } state_t;

    logic [1:0]           sync_q;
    logic                 sync;
    state_t               state_q, state_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic [2:0]           pmode_q, pmode_d;
    logic                 two_stop_q, two_stop_d;

    logic                 tick_wrap_c;
    logic                 sample_c;
    logic                 bit_end_c;
    logic                 par_en_c;
    logic                 par_ok_c;
    logic                 push_c;
    logic [ENTRY_W-1:0]   push_entry_c;

    logic [ENTRY_W-1:0]   mem [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic                 overrun_q;
    logic                 full_c, empty_c, do_push_c, do_pop_c;
    logic [ENTRY_W-1:0]   head_c;

    // Metastability guard on the asynchronous serial line
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_din};
        end
    end

    assign sync = sync_q[1];

    assign tick_wrap_c = (tick_q == TICK_W'(BAUD_PERIOD - 1));
    assign sample_c    = tick_wrap_c && (phase_q == PHASE_W'(HALF - 1));
    assign bit_end_c   = tick_wrap_c && (phase_q == PHASE_W'(ONE_BAUD_PHASE - 1));
    assign par_en_c    = (pmode_q >= 3'd1) && (pmode_q <= 3'd4);

    always_comb begin
        par_ok_c = 1'b1;
        case (pmode_q)
            3'd1:    par_ok_c = ((^shift_q) ^ sync) == 1'b1;
            3'd2:    par_ok_c = ((^shift_q) ^ sync) == 1'b0;
            3'd3:    par_ok_c = (sync == 1'b1);
            3'd4:    par_ok_c = (sync == 1'b0);
            default: par_ok_c = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            tick_q     <= '0;
            phase_q    <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            pmode_q    <= '0;
            two_stop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            phase_q    <= phase_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            pmode_q    <= pmode_d;
            two_stop_q <= two_stop_d;
        end
    end

    // Frame FSM: bit timing, sampling, and the push at the last stop-bit sample
    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q;
        phase_d      = phase_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        pmode_d      = pmode_q;
        two_stop_d   = two_stop_q;
        push_c       = 1'b0;
        push_entry_c = '0;

        if (state_q != IDLE) begin
            if (tick_wrap_c) begin
                tick_d  = '0;
                phase_d = (phase_q == PHASE_W'(ONE_BAUD_PHASE - 1)) ? '0 : phase_q + PHASE_W'(1);
            end else begin
                tick_d = tick_q + TICK_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                tick_d     = '0;
                phase_d    = '0;
                bit_d      = '0;
                perr_d     = 1'b0;
                ferr_d     = 1'b0;
                pmode_d    = parity_mode;
                two_stop_d = two_stop;
                if (!sync) begin
                    state_d = START;
                end
            end
            START: begin
                if (sample_c && sync) begin
                    state_d = IDLE;
                end else if (bit_end_c) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (sample_c) begin
                    shift_d = {sync, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + BIT_W'(1);
                end
                if (bit_end_c && (bit_q == BIT_W'(DATA_BITS))) begin
                    state_d = par_en_c ? PARITY : STOP1;
                end
            end
            PARITY: begin
                if (sample_c) begin
                    perr_d = !par_ok_c;
                end
                if (bit_end_c) begin
                    state_d = STOP1;
                end
            end
            STOP1: begin
                if (sample_c) begin
                    ferr_d = ferr_q | !sync;
                    if (!two_stop_q) begin
                        state_d = IDLE;
                        push_c  = 1'b1;
                    end
                end else if (bit_end_c) begin
                    state_d = STOP2;
                end
            end
            STOP2: begin
                if (sample_c) begin
                    ferr_d  = ferr_q | !sync;
                    state_d = IDLE;
                    push_c  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        push_entry_c = {ferr_d, perr_q, shift_q};
    end

    assign full_c    = (count_q == CNT_W'(DEPTH));
    assign empty_c   = (count_q == '0);
    assign do_pop_c  = rd_en && !empty_c;
    assign do_push_c = push_c && (!full_c || do_pop_c);

    // Storage is not reset; only pointers and count define validity
    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem[wr_ptr_q] <= push_entry_c;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (do_push_c) begin
                wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            end
            if (do_pop_c) begin
                rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            end
            case ({do_push_c, do_pop_c})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (push_c && full_c && !do_pop_c) begin
                overrun_q <= 1'b1;
            end else if (clr_ovr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign head_c     = empty_c ? '0 : mem[rd_ptr_q];
    assign rx_dout    = head_c[DATA_BITS-1:0];
    assign rx_perr    = head_c[DATA_BITS];
    assign rx_ferr    = head_c[DATA_BITS+1];
    assign rx_valid   = !empty_c;
    assign fifo_count = count_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: frames are serialised at 16 clocks/bit,
// expected entries are queued at issue time and checked as they leave the FIFO.
module tb_uart_rx_fifo;

    localparam int unsigned BIT_CLKS = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_din;
    logic [2:0] parity_mode;
    logic       two_stop;
    logic       rd_en;
    logic       clr_ovr;
    logic [7:0] rx_dout;
    logic       rx_perr;
    logic       rx_ferr;
    logic       rx_valid;
    logic [4:0] fifo_count;
    logic       overrun;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   auto_pop = 1'b0;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .DATA_BITS     (8),
        .BAUD_PERIOD   (4),
        .ONE_BAUD_PHASE(4),
        .FIFO_AW       (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_din     (rx_din),
        .parity_mode(parity_mode),
        .two_stop   (two_stop),
        .rd_en      (rd_en),
        .clr_ovr    (clr_ovr),
        .rx_dout    (rx_dout),
        .rx_perr    (rx_perr),
        .rx_ferr    (rx_ferr),
        .rx_valid   (rx_valid),
        .fifo_count (fifo_count),
        .overrun    (overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        rx_din = b;
        idle(BIT_CLKS);
    endtask

    // A bad stop bit is held low for 12 of its 16 clocks so the line is high again
    // before the receiver re-qualifies the low level as a new start bit.
    task automatic drive_stop(input bit is_bad);
        if (is_bad) begin
            rx_din = 1'b0;
            idle(12);
            rx_din = 1'b1;
            idle(4);
        end else begin
            drive_bit(1'b1);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit has_par, input logic pbit,
                              input bit two, input int bad_stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            drive_bit(d[i]);
        end
        if (has_par) begin
            drive_bit(pbit);
        end
        drive_stop(bad_stop == 1);
        if (two) begin
            drive_stop(bad_stop == 2);
        end
        drive_bit(1'b1);
    endtask

    task automatic expect_rx(input logic [7:0] d, input logic p, input logic f);
        exp_t e;
        e.data = d;
        e.perr = p;
        e.ferr = f;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rx_valid) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
        check({name, "_valid_after_drain"}, 32'(rx_valid), 32'd0);
    endtask

    // Monitor: pops and compares the FIFO head whenever draining is enabled
    initial begin
        exp_t e;
        rd_en = 1'b0;
        forever begin
            @(negedge clk);
            rd_en = 1'b0;
            if (auto_pop && rx_valid && !reset) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_entry: got data=0x%0h perr=%0b ferr=%0b expected no entry",
                             rx_dout, rx_perr, rx_ferr);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_dout", 32'(rx_dout), 32'(e.data));
                    check("rx_perr", 32'(rx_perr), 32'(e.perr));
                    check("rx_ferr", 32'(rx_ferr), 32'(e.ferr));
                end
                rd_en = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected test completion");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        rx_din      = 1'b1;
        parity_mode = 3'd0;
        two_stop    = 1'b0;
        clr_ovr     = 1'b0;
        idle(4);
        reset = 1'b0;
        idle(1);

        check("reset_count", 32'(fifo_count), 32'd0);
        check("reset_valid", 32'(rx_valid), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        check("reset_empty_dout", 32'(rx_dout), 32'd0);
        check("reset_empty_flags", 32'({rx_perr, rx_ferr}), 32'd0);

        // 8N1 frame held in the FIFO before draining
        auto_pop = 1'b0;
        expect_rx(8'h55, 1'b0, 1'b0);
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 0);
        check("8n1_count", 32'(fifo_count), 32'd1);
        check("8n1_valid", 32'(rx_valid), 32'd1);
        auto_pop = 1'b1;
        wait_drain("8n1");

        // Parity modes on 0xA3 (four ones)
        parity_mode = 3'd2;
        expect_rx(8'hA3, 1'b1, 1'b0);
        send_frame(8'hA3, 1'b1, 1'b1, 1'b0, 0);
        expect_rx(8'hA3, 1'b0, 1'b0);
        send_frame(8'hA3, 1'b1, 1'b0, 1'b0, 0);
        parity_mode = 3'd1;
        expect_rx(8'hA3, 1'b0, 1'b0);
        send_frame(8'hA3, 1'b1, 1'b1, 1'b0, 0);
        parity_mode = 3'd3;
        expect_rx(8'hA3, 1'b1, 1'b0);
        send_frame(8'hA3, 1'b1, 1'b0, 1'b0, 0);
        parity_mode = 3'd4;
        expect_rx(8'h3A, 1'b0, 1'b0);
        send_frame(8'h3A, 1'b1, 1'b0, 1'b0, 0);
        parity_mode = 3'd7;
        expect_rx(8'h5A, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 0);
        wait_drain("parity");

        // Mode change mid-frame must not affect the frame in flight
        parity_mode = 3'd0;
        expect_rx(8'hC3, 1'b0, 1'b0);
        fork
            send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 0);
            begin
                idle(40);
                parity_mode = 3'd2;
            end
        join
        parity_mode = 3'd0;
        wait_drain("latched_mode");

        // Framing errors on one and two stop bits
        expect_rx(8'h3C, 1'b0, 1'b1);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1);
        two_stop = 1'b1;
        expect_rx(8'h3C, 1'b0, 1'b1);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 2);
        expect_rx(8'h96, 1'b0, 1'b0);
        send_frame(8'h96, 1'b0, 1'b0, 1'b1, 0);
        two_stop = 1'b0;
        wait_drain("framing");

        // Short glitch is a false start
        rx_din = 1'b0;
        idle(4);
        rx_din = 1'b1;
        idle(48);
        check("glitch_count", 32'(fifo_count), 32'd0);
        check("glitch_valid", 32'(rx_valid), 32'd0);
        expect_rx(8'hE1, 1'b0, 1'b0);
        send_frame(8'hE1, 1'b0, 1'b0, 1'b0, 0);
        wait_drain("after_glitch");

        // Fill past capacity: seventeenth frame dropped
        auto_pop = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) begin
                expect_rx(8'(i), 1'b0, 1'b0);
            end
            send_frame(8'(i), 1'b0, 1'b0, 1'b0, 0);
        end
        check("full_count", 32'(fifo_count), 32'd16);
        check("full_overrun", 32'(overrun), 32'd1);
        check("full_head", 32'(rx_dout), 32'd0);
        check("full_valid", 32'(rx_valid), 32'd1);
        auto_pop = 1'b1;
        wait_drain("full_drain");
        check("overrun_sticky", 32'(overrun), 32'd1);
        clr_ovr = 1'b1;
        idle(1);
        clr_ovr = 1'b0;
        check("overrun_cleared", 32'(overrun), 32'd0);

        // Reset during DATA discards stored and partial frames
        auto_pop = 1'b0;
        send_frame(8'h77, 1'b0, 1'b0, 1'b0, 0);
        check("pre_reset_count", 32'(fifo_count), 32'd1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rx_din = 1'b1;
        reset  = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(40);
        check("midreset_count", 32'(fifo_count), 32'd0);
        check("midreset_valid", 32'(rx_valid), 32'd0);
        check("midreset_overrun", 32'(overrun), 32'd0);
        check("midreset_dout", 32'(rx_dout), 32'd0);
        auto_pop = 1'b1;
        expect_rx(8'h81, 1'b0, 1'b0);
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 0);
        wait_drain("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
